uart_rx_cfg: RTL and testbench

Configurable UART receiver and parametrised successor to the fixed 8N1 receiver. It supports 5–9 data bits, none/odd/even parity, 1 or 2 stop bits, and an internal baud counter. Each bit is taken as a 3-sample majority vote around mid-bit, and parity and framing errors are flagged per frame. It sits between the board RX pin and the byte consumers, such as the loopback and command-parser blocks, in place of the fixed receiver.

---
 rtl/uart_rx_cfg_if.sv | 28 ++
 rtl/uart_rx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - serial line and received-word bundle for uart_rx_cfg
// Ports (master = receiver side):
//   i_rx    serial line into the receiver, idles high
//   o_data  last received word, LSB = first data bit
//   o_rcv   one-cycle strobe when o_data/o_perr/o_ferr update
//   o_perr  parity error of last frame
//   o_ferr  framing error of last frame
//   o_busy  receiver not idle
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_rcv;
  logic                 o_perr;
  logic                 o_ferr;
  logic                 o_busy;

  modport master (
    input  i_rx,
    output o_data, o_rcv, o_perr, o_ferr, o_busy
  );

  modport slave (
    output i_rx,
    input  o_data, o_rcv, o_perr, o_ferr, o_busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver (5-9 data bits, parity, 1/2 stop)
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   uart_rx_cfg_if.master: i_rx in; o_data, o_rcv, o_perr, o_ferr, o_busy out
module uart_rx_cfg #(
  parameter int BAUD      = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rstn,
  uart_rx_cfg_if.master bus
);

  localparam int             CW        = $clog2(BAUD);
  localparam logic [CW-1:0]  M_LO      = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0]  M_MID     = CW'(BAUD / 2);
  localparam logic [CW-1:0]  M_HI      = CW'(BAUD / 2 + 1);
  localparam logic [CW-1:0]  WRAP      = CW'(BAUD - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic           PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_DONE,
    S_WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic                 samp0;
  logic                 samp1;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 vote;
  logic                 decide;
  logic                 wrap;

  // Third sample is the live rx_s at the decision edge.
  assign vote   = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign decide = (cnt == M_HI);
  assign wrap   = (cnt == WRAP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.i_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samp0 <= 1'b0;
      samp1 <= 1'b0;
    end else begin
      if (cnt == M_LO)  samp0 <= rx_s;
      if (cnt == M_MID) samp1 <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      bus.o_data <= '0;
      bus.o_rcv  <= 1'b0;
      bus.o_perr <= 1'b0;
      bus.o_ferr <= 1'b0;
      bus.o_busy <= 1'b0;
    end else begin
      bus.o_rcv <= 1'b0;

      if (state == S_IDLE || state == S_WAIT_HIGH || wrap) cnt <= '0;
      else                                                  cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state      <= S_START;
            idx        <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            bus.o_busy <= 1'b1;
          end
        end

        S_START: begin
          if (decide && vote) begin
            state      <= S_IDLE;
            bus.o_busy <= 1'b0;
          end else if (wrap) begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (decide) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            if (idx == LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        S_PAR: begin
          if (decide) perr <= ((^shreg) ^ vote) != PAR_ODD;
          if (wrap)   state <= S_STOP;
        end

        S_STOP: begin
          // The last stop bit completes the frame at its decision point so a
          // following start edge at the nominal bit end is not missed.
          if (decide) begin
            if (idx == LAST_STOP) begin
              state      <= S_DONE;
              bus.o_data <= shreg;
              bus.o_perr <= perr;
              bus.o_ferr <= ferr | ~vote;
              bus.o_rcv  <= 1'b1;
            end else begin
              ferr <= ferr | ~vote;
            end
          end
          if (wrap) idx <= idx + 1'b1;
        end

        S_DONE: begin
          // After a framing error the line may be in break; hold off new
          // starts until it has been seen high.
          state      <= bus.o_ferr ? S_WAIT_HIGH : S_IDLE;
          bus.o_busy <= bus.o_ferr;
        end

        S_WAIT_HIGH: begin
          if (rx_s) begin
            state      <= S_IDLE;
            bus.o_busy <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if8 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if7 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if17 ();

  uart_rx_cfg #(.BAUD(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
    .clk(clk), .rstn(rstn), .bus(if8));
  uart_rx_cfg #(.BAUD(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
    .clk(clk), .rstn(rstn), .bus(if7));
  uart_rx_cfg #(.BAUD(17), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut17 (
    .clk(clk), .rstn(rstn), .bus(if17));

  int       cnt8 = 0, cnt7 = 0, cnt17 = 0;
  int       cyc8 = 0, cyc7 = 0, cyc17 = 0, prev_cyc17 = 0;
  logic [7:0] data17 = 8'h0, prev_data17 = 8'h0;

  always @(negedge clk) begin
    if (if8.o_rcv === 1'b1) begin
      cnt8++;
      cyc8 = cyc;
    end
    if (if7.o_rcv === 1'b1) begin
      cnt7++;
      cyc7 = cyc;
    end
    if (if17.o_rcv === 1'b1) begin
      cnt17++;
      prev_cyc17  = cyc17;
      prev_data17 = data17;
      cyc17       = cyc;
      data17      = if17.o_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       if8.i_rx  = v;
      1:       if7.i_rx  = v;
      default: if17.i_rx = v;
    endcase
  endtask

  // Drives n bits LSB first, baud cycles each; optional one-cycle inversion
  // at cycle gcyc of bit gbit.
  task automatic send(input int sel, input logic [15:0] bits, input int n,
                      input int baud, input int gbit, input int gcyc);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < baud; j++) begin
        v = bits[i] ^ ((i == gbit) && (j == gcyc));
        set_rx(sel, v);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c;
  int base;

  initial begin
    if8.i_rx  = 1'b1;
    if7.i_rx  = 1'b1;
    if17.i_rx = 1'b1;
    rstn      = 1'b0;
    idle(3);
    check("reset_data", 32'(if8.o_data), 32'h0);
    check("reset_rcv",  32'(if8.o_rcv),  32'h0);
    check("reset_perr", 32'(if8.o_perr), 32'h0);
    check("reset_ferr", 32'(if8.o_ferr), 32'h0);
    check("reset_busy", 32'(if8.o_busy), 32'h0);
    rstn = 1'b1;
    idle(5);

    // 8N1 0xA5 with exact latency
    c = cyc;
    send(0, {1'b1, 8'hA5, 1'b0}, 10, 16, -1, 0);
    idle(20);
    check("a5_count",   32'(cnt8),         32'd1);
    check("a5_data",    32'(if8.o_data),   32'hA5);
    check("a5_perr",    32'(if8.o_perr),   32'h0);
    check("a5_ferr",    32'(if8.o_ferr),   32'h0);
    check("a5_latency", 32'(cyc8 - (c + 1)), 32'd156);
    check("a5_busy",    32'(if8.o_busy),   32'h0);

    // 7E2 0x35: good parity then inverted parity
    c = cyc;
    send(1, {2'b11, 1'b0, 7'h35, 1'b0}, 11, 16, -1, 0);
    idle(20);
    check("e2_count1",   32'(cnt7),           32'd1);
    check("e2_data1",    32'(if7.o_data),     32'h35);
    check("e2_perr1",    32'(if7.o_perr),     32'h0);
    check("e2_ferr1",    32'(if7.o_ferr),     32'h0);
    check("e2_latency",  32'(cyc7 - (c + 1)), 32'd172);
    send(1, {2'b11, 1'b1, 7'h35, 1'b0}, 11, 16, -1, 0);
    idle(20);
    check("e2_count2",   32'(cnt7),           32'd2);
    check("e2_data2",    32'(if7.o_data),     32'h35);
    check("e2_perr2",    32'(if7.o_perr),     32'h1);

    // False start: 3 clocks low
    base = cnt8;
    set_rx(0, 1'b0);
    idle(3);
    check("fs_busy_high", 32'(if8.o_busy), 32'h1);
    set_rx(0, 1'b1);
    idle(40);
    check("fs_busy_low",  32'(if8.o_busy), 32'h0);
    check("fs_no_rcv",    32'(cnt8),       32'(base));

    // Glitch at centre of data bit 2 of 0x00
    send(0, {1'b1, 8'h00, 1'b0}, 10, 16, 3, 8);
    idle(20);
    check("gl_count", 32'(cnt8),       32'(base + 1));
    check("gl_data",  32'(if8.o_data), 32'h00);
    check("gl_ferr",  32'(if8.o_ferr), 32'h0);

    // Stop bit low then break for 40 bit times
    base = cnt8;
    send(0, {1'b0, 8'h3C, 1'b0}, 10, 16, -1, 0);
    idle(40 * 16);
    check("brk_count",     32'(cnt8),       32'(base + 1));
    check("brk_data",      32'(if8.o_data), 32'h3C);
    check("brk_ferr",      32'(if8.o_ferr), 32'h1);
    check("brk_perr",      32'(if8.o_perr), 32'h0);
    check("brk_busy_held", 32'(if8.o_busy), 32'h1);
    set_rx(0, 1'b1);
    idle(10);
    check("brk_busy_low",  32'(if8.o_busy), 32'h0);
    check("brk_count_end", 32'(cnt8),       32'(base + 1));

    // Back-to-back 0x00, 0xFF at BAUD=17
    c = cyc;
    send(2, {1'b1, 8'h00, 1'b0}, 10, 17, -1, 0);
    send(2, {1'b1, 8'hFF, 1'b0}, 10, 17, -1, 0);
    idle(30);
    check("b2b_count",    32'(cnt17),              32'd2);
    check("b2b_data1",    32'(prev_data17),        32'h00);
    check("b2b_data2",    32'(if17.o_data),        32'hFF);
    check("b2b_latency",  32'(prev_cyc17 - (c + 1)), 32'd165);
    check("b2b_interval", 32'(cyc17 - prev_cyc17), 32'd170);

    // Reset during data bit 4
    base = cnt8;
    send(0, {1'b1, 8'hA5, 1'b0}, 5, 16, -1, 0);
    set_rx(0, 1'b0);
    idle(8);
    check("mid_busy_pre", 32'(if8.o_busy), 32'h1);
    rstn = 1'b0;
    #1;
    check("mid_rst_data", 32'(if8.o_data), 32'h0);
    check("mid_rst_ferr", 32'(if8.o_ferr), 32'h0);
    check("mid_rst_busy", 32'(if8.o_busy), 32'h0);
    check("mid_rst_rcv",  32'(if8.o_rcv),  32'h0);
    set_rx(0, 1'b1);
    idle(2);
    rstn = 1'b1;
    idle(48);
    check("mid_no_rcv",   32'(cnt8),       32'(base));
    check("mid_idle",     32'(if8.o_busy), 32'h0);
    send(0, {1'b1, 8'h5A, 1'b0}, 10, 16, -1, 0);
    idle(20);
    check("post_count",   32'(cnt8),       32'(base + 1));
    check("post_data",    32'(if8.o_data), 32'h5A);
    check("post_ferr",    32'(if8.o_ferr), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
